boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Power-on loader that copies a program image from SPI NOR/EEPROM into 6502 RAM, then releases the CPU.
- Parametrised in flash address length, source/destination base, image length, SCK rate and RAM address width.
- Adds over the first-generation loader: optional trailing checksum with error reporting, a `start` re-boot request, and a power-down command to the flash after loading.
- Sits between the FPGA's SPI flash pins and the 6502 bus arbiter. It owns the bus while `busen`=0.

Parameters:
- FLASH_ADDR_BYTES, 3: address bytes sent after READ (2 for 25AA512 bench model, 3 for AT25M01/W25Q80).
- FLASH_BASE, 24'h080000: first flash byte read; only the low FLASH_ADDR_BYTES*8 bits are sent.
- RAM_ADDR_BITS, 19: width of `address`.
- RAM_BASE, 19'h0F000: RAM address of the first image byte.
- LENGTH, 4096: number of image bytes; valid range 1..65536.
- SCK_DIV, 1: clock cycles per SCK half-period; must be >= 1.
- STARTUP_CYCLES, 64: idle cycles after reset before flash access.
- WAKE_CYCLES, 800: cycles CS stays high after 0xAB (100 us at 8 MHz).
- CHECKSUM_EN, 1: read one extra byte; the 8-bit sum of image plus that byte must be 0.
- POWER_DOWN_EN, 1: send 0xB9 after a successful load.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; re-runs the load; honoured only in S_DONE or S_FAIL
- flash_so  in  1  SPI MISO
- flash_si  out  1  SPI MOSI
- flash_sck  out  1  SPI clock, mode 0
- flash_cs_n  out  1  SPI chip select
- address  out  RAM_ADDR_BITS  RAM write address
- data  out  8  RAM write data
- rw  out  1  0 = write strobe
- busen  out  1  1 = 6502 bus drivers enabled
- cpu_reset_n  out  1  0 = 6502 held in reset
- booting  out  1  1 while loader active
- error  out  1  1 = checksum mismatch, sticky until the next start or reset

Behaviour:
- Reset values, applied asynchronously:
  - flash_si=0, flash_sck=0, flash_cs_n=1.
  - address=0, data=0, rw=1.
  - busen=0, cpu_reset_n=0, booting=1, error=0.
  - State S_HOLD, counters 0.
- SPI engine:
  - Mode 0, MSB first.
  - SI is set up while SCK is low and at least one cycle before the rising edge.
  - SO is sampled on the clock that drives SCK 1->0.
  - Each bit takes 2*SCK_DIV cycles; SCK idles low.
- States:
  - S_HOLD: count STARTUP_CYCLES, then go to S_WAKE.
  - S_WAKE: CS low, shift 0xAB (8 bits), CS high, go to S_WAKE_WAIT.
  - S_WAKE_WAIT: count WAKE_CYCLES, then go to S_CMD.
  - S_CMD: CS low, shift 0x03 followed by the FLASH_BASE address (8+8*FLASH_ADDR_BYTES bits). CS stays low.
  - S_BYTE: shift in 8 bits.
  - S_WRITE: one cycle.
    - address = RAM_BASE + offset, truncated to RAM_ADDR_BITS (wrap allowed).
    - data = received byte, rw=0.
    - Running 8-bit sum += byte.
  - S_WRITE_END: rw=1; address and data held this cycle.
    - If offset < LENGTH-1: offset+1, go to S_BYTE.
    - Otherwise go to S_CHECK (CHECKSUM_EN) or S_SLEEP.
  - S_CHECK: shift in 1 byte, which is not written to RAM.
    - If (sum + byte) mod 256 == 0: go to S_SLEEP.
    - Otherwise go to S_FAIL.
  - S_SLEEP: CS high for at least 1 cycle.
    - If POWER_DOWN_EN: CS low, shift 0xB9, CS high.
    - Then go to S_RELEASE.
  - S_RELEASE: one cycle, then go to S_DONE.
    - address=0, data=0, rw=1, flash_sck=0, flash_cs_n=1.
    - busen=1, cpu_reset_n=1, booting=0.
  - S_FAIL: flash_cs_n=1, booting=0, error=1. busen and cpu_reset_n stay 0.
  - S_DONE: idle.
- start handling:
  - In S_DONE or S_FAIL, start sets busen=0, cpu_reset_n=0, booting=1, error=0, and goes to S_WAKE, skipping S_HOLD.
  - In every other state start is ignored.
- Widths:
  - offset is 16 bits; LENGTH=65536 means terminal offset 16'hFFFF with no overflow.
  - Sum is 8 bits, wrapping.
- flash_si is 0 whenever not shifting and whenever booting=0.
- Reset asserted mid-transfer: CS goes high immediately and rw=1 immediately; no partial write strobe survives.

Decomposition:
- Package boot_pkg holds:
  - state enum;
  - flash opcodes CMD_RELEASE_PD=8'hAB, CMD_READ=8'h03, CMD_POWER_DOWN=8'hB9;
  - helper constant CMD_BITS = 8+8*FLASH_ADDR_BYTES.
- Sub-module boot_spi_shift: one-transaction shifter.
  - Parameter: SCK_DIV.
  - Inputs: go, nbits[5:0] (1..32), tx[31:0], so.
  - Outputs: sck, si, busy, done (1-cycle pulse), rx[7:0] (last 8 bits).
- The top-level FSM owns CS.

Test Plan:
- Sequence with FLASH_ADDR_BYTES=2, FLASH_BASE=16'hE000, LENGTH=16, CHECKSUM_EN=0, 25AA512 model holding 0x00..0x0F:
  - 0xAB, then 0x03 E0 00 on SI;
  - 16 rw pulses at 0x0F000..0x0F00F with data 0x00..0x0F;
  - then 0xB9;
  - busen=1 and cpu_reset_n=1 together with booting=0.
- Checksum pass: image 0x01..0x0F plus 0x88 (sum 0x78+0x88 = 0x00) -> error=0, CPU released.
- Checksum fail: same image, check byte 0x87 -> S_FAIL, error=1, cpu_reset_n=0, busen=0, flash_cs_n=1. A following start pulse clears error and repeats the load.
- SCK_DIV=3 -> SCK high and low phases each 3 cycles; written data is identical to the SCK_DIV=1 case.
- Async reset asserted during the 5th byte -> same cycle: flash_cs_n=1, rw=1, booting=1, busen=0. After release, the full sequence restarts from S_HOLD (64 idle cycles).
- start pulsed during S_BYTE -> ignored; exactly LENGTH writes occur. RAM_BASE=19'h7FFF8, LENGTH=16 -> addresses wrap 0x7FFFF -> 0x00000.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the SPI-flash-to-RAM boot loader.
package boot_pkg;

   typedef enum logic [3:0] {
      S_HOLD      = 4'd0,
      S_WAKE      = 4'd1,
      S_WAKE_WAIT = 4'd2,
      S_CMD       = 4'd3,
      S_BYTE      = 4'd4,
      S_WRITE     = 4'd5,
      S_WRITE_END = 4'd6,
      S_CHECK     = 4'd7,
      S_SLEEP     = 4'd8,
      S_RELEASE   = 4'd9,
      S_FAIL      = 4'd10,
      S_DONE      = 4'd11
   } boot_state_e;

   localparam logic [7:0] CMD_RELEASE_PD = 8'hAB;
   localparam logic [7:0] CMD_READ       = 8'h03;
   localparam logic [7:0] CMD_POWER_DOWN = 8'hB9;

   // Length of the READ opcode plus address phase.
   function automatic int cmd_bits(input int addr_bytes);
      return 8 + 8 * addr_bytes;
   endfunction

endpackage

// File: rtl/boot_spi_shift.sv
// One-transaction SPI mode-0 shifter: sends nbits of tx MSB first and keeps the last 8 bits received.
module boot_spi_shift #(
   parameter int SCK_DIV = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        go_i,
   input  logic [5:0]  nbits_i,
   input  logic [31:0] tx_i,
   input  logic        so_i,
   output logic        sck_o,
   output logic        si_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [7:0]  rx_o
);

   localparam logic [15:0] DIV_LAST = 16'(SCK_DIV - 1);

   logic        sck_q, si_q, busy_q, done_q;
   logic [15:0] div_q;
   logic [5:0]  bits_q;
   logic [31:0] sh_q;
   logic [7:0]  rx_q;
   logic [31:0] tx_align_s;

   // tx is right-justified; left-justify it so the first bit sits in bit 31.
   always_comb begin
      tx_align_s = tx_i << (6'd32 - nbits_i);
   end

   // Bit engine: SI changes only with SCK low, SO is captured on the edge that lowers SCK.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sck_q  <= 1'b0;
         si_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         div_q  <= 16'd0;
         bits_q <= 6'd0;
         sh_q   <= 32'd0;
         rx_q   <= 8'd0;
      end else begin
         done_q <= 1'b0;
         if (!busy_q) begin
            if (go_i) begin
               busy_q <= 1'b1;
               sh_q   <= tx_align_s;
               si_q   <= tx_align_s[31];
               bits_q <= nbits_i;
               div_q  <= 16'd0;
               sck_q  <= 1'b0;
            end else begin
               si_q <= 1'b0;
            end
         end else if (div_q != DIV_LAST) begin
            div_q <= div_q + 16'd1;
         end else begin
            div_q <= 16'd0;
            if (!sck_q) begin
               sck_q <= 1'b1;
            end else begin
               sck_q  <= 1'b0;
               rx_q   <= {rx_q[6:0], so_i};
               sh_q   <= {sh_q[30:0], 1'b0};
               bits_q <= bits_q - 6'd1;
               if (bits_q == 6'd1) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  si_q   <= 1'b0;
               end else begin
                  si_q <= sh_q[30];
               end
            end
         end
      end
   end

   assign sck_o  = sck_q;
   assign si_o   = si_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign rx_o   = rx_q;

endmodule

// File: rtl/boot_loader.sv
// Power-on loader: wakes the SPI flash, copies an image into 6502 RAM, verifies an optional
// trailing checksum, powers the flash down and releases the CPU.
module boot_loader
   import boot_pkg::*;
#(
   parameter int                       FLASH_ADDR_BYTES = 3,
   parameter logic [23:0]              FLASH_BASE       = 24'h080000,
   parameter int                       RAM_ADDR_BITS    = 19,
   parameter logic [RAM_ADDR_BITS-1:0] RAM_BASE         = 19'h0F000,
   parameter int                       LENGTH           = 4096,
   parameter int                       SCK_DIV          = 1,
   parameter int                       STARTUP_CYCLES   = 64,
   parameter int                       WAKE_CYCLES      = 800,
   parameter bit                       CHECKSUM_EN      = 1'b1,
   parameter bit                       POWER_DOWN_EN    = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     flash_so,
   output logic                     flash_si,
   output logic                     flash_sck,
   output logic                     flash_cs_n,
   output logic [RAM_ADDR_BITS-1:0] address,
   output logic [7:0]               data,
   output logic                     rw,
   output logic                     busen,
   output logic                     cpu_reset_n,
   output logic                     booting,
   output logic                     error
);

   localparam int          CMD_BITS  = cmd_bits(FLASH_ADDR_BYTES);
   localparam logic [31:0] BASE_MASK = (32'h1 << (8 * FLASH_ADDR_BYTES)) - 32'h1;
   localparam logic [31:0] READ_TX   = (32'(CMD_READ) << (8 * FLASH_ADDR_BYTES)) | (32'(FLASH_BASE) & BASE_MASK);
   localparam logic [15:0] LAST_OFF  = 16'(LENGTH - 1);

   boot_state_e              state_q;
   logic [31:0]              wait_q;
   logic [15:0]              offset_q;
   logic [7:0]               sum_q;
   logic                     cs_q, rw_q, busen_q, cpu_q, booting_q, error_q;
   logic [RAM_ADDR_BITS-1:0] address_q;
   logic [7:0]               data_q;
   logic                     go_q, spi_wait_q;
   logic [5:0]               nbits_q, nbits_d;
   logic [31:0]              tx_q, tx_d;
   logic                     shift_state_s;
   logic                     spi_sck_s, spi_si_s, spi_busy_s, spi_done_s;
   logic [7:0]               spi_rx_s;

   boot_spi_shift #(.SCK_DIV(SCK_DIV)) u_shift (
      .clk_i   (clock),
      .rst_i   (reset),
      .go_i    (go_q),
      .nbits_i (nbits_q),
      .tx_i    (tx_q),
      .so_i    (flash_so),
      .sck_o   (spi_sck_s),
      .si_o    (spi_si_s),
      .busy_o  (spi_busy_s),
      .done_o  (spi_done_s),
      .rx_o    (spi_rx_s)
   );

   // Which states run a flash transaction, and what each one shifts out.
   always_comb begin
      shift_state_s = 1'b1;
      nbits_d       = 6'd8;
      tx_d          = 32'd0;
      case (state_q)
         S_WAKE:  tx_d = {24'd0, CMD_RELEASE_PD};
         S_CMD: begin
            nbits_d = 6'(CMD_BITS);
            tx_d    = READ_TX;
         end
         S_BYTE:  tx_d = 32'd0;
         S_CHECK: tx_d = 32'd0;
         S_SLEEP: begin
            shift_state_s = POWER_DOWN_EN;
            tx_d          = {24'd0, CMD_POWER_DOWN};
         end
         default: shift_state_s = 1'b0;
      endcase
   end

   // Main sequencer; it owns chip select and all bus-side outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_HOLD;
         wait_q     <= 32'd0;
         offset_q   <= 16'd0;
         sum_q      <= 8'd0;
         cs_q       <= 1'b1;
         address_q  <= '0;
         data_q     <= 8'd0;
         rw_q       <= 1'b1;
         busen_q    <= 1'b0;
         cpu_q      <= 1'b0;
         booting_q  <= 1'b1;
         error_q    <= 1'b0;
         go_q       <= 1'b0;
         spi_wait_q <= 1'b0;
         nbits_q    <= 6'd0;
         tx_q       <= 32'd0;
      end else begin
         go_q <= 1'b0;
         if (shift_state_s && !spi_wait_q && !spi_busy_s) begin
            cs_q       <= 1'b0;
            go_q       <= 1'b1;
            nbits_q    <= nbits_d;
            tx_q       <= tx_d;
            spi_wait_q <= 1'b1;
         end
         case (state_q)
            S_HOLD: begin
               if (wait_q == 32'(STARTUP_CYCLES - 1)) begin
                  wait_q  <= 32'd0;
                  state_q <= S_WAKE;
               end else begin
                  wait_q <= wait_q + 32'd1;
               end
            end
            S_WAKE: begin
               if (spi_wait_q && spi_done_s) begin
                  spi_wait_q <= 1'b0;
                  cs_q       <= 1'b1;
                  state_q    <= S_WAKE_WAIT;
               end
            end
            S_WAKE_WAIT: begin
               if (wait_q == 32'(WAKE_CYCLES - 1)) begin
                  wait_q  <= 32'd0;
                  state_q <= S_CMD;
               end else begin
                  wait_q <= wait_q + 32'd1;
               end
            end
            S_CMD: begin
               if (spi_wait_q && spi_done_s) begin
                  spi_wait_q <= 1'b0;
                  state_q    <= S_BYTE;
               end
            end
            S_BYTE: begin
               if (spi_wait_q && spi_done_s) begin
                  spi_wait_q <= 1'b0;
                  address_q  <= RAM_BASE + RAM_ADDR_BITS'(offset_q);
                  data_q     <= spi_rx_s;
                  rw_q       <= 1'b0;
                  state_q    <= S_WRITE;
               end
            end
            S_WRITE: begin
               rw_q    <= 1'b1;
               sum_q   <= sum_q + data_q;
               state_q <= S_WRITE_END;
            end
            S_WRITE_END: begin
               if (offset_q < LAST_OFF) begin
                  offset_q <= offset_q + 16'd1;
                  state_q  <= S_BYTE;
               end else if (CHECKSUM_EN) begin
                  state_q <= S_CHECK;
               end else begin
                  cs_q    <= 1'b1;
                  state_q <= S_SLEEP;
               end
            end
            S_CHECK: begin
               if (spi_wait_q && spi_done_s) begin
                  spi_wait_q <= 1'b0;
                  cs_q       <= 1'b1;
                  if (8'(sum_q + spi_rx_s) == 8'h00) begin
                     state_q <= S_SLEEP;
                  end else begin
                     booting_q <= 1'b0;
                     error_q   <= 1'b1;
                     state_q   <= S_FAIL;
                  end
               end
            end
            S_SLEEP: begin
               // Entered with CS already high, so CS spends at least a cycle high before 0xB9.
               if (!POWER_DOWN_EN || (spi_wait_q && spi_done_s)) begin
                  spi_wait_q <= 1'b0;
                  cs_q       <= 1'b1;
                  address_q  <= '0;
                  data_q     <= 8'd0;
                  rw_q       <= 1'b1;
                  busen_q    <= 1'b1;
                  cpu_q      <= 1'b1;
                  booting_q  <= 1'b0;
                  state_q    <= S_RELEASE;
               end
            end
            S_RELEASE: state_q <= S_DONE;
            S_FAIL, S_DONE: begin
               if (start) begin
                  busen_q   <= 1'b0;
                  cpu_q     <= 1'b0;
                  booting_q <= 1'b1;
                  error_q   <= 1'b0;
                  rw_q      <= 1'b1;
                  cs_q      <= 1'b1;
                  offset_q  <= 16'd0;
                  sum_q     <= 8'd0;
                  wait_q    <= 32'd0;
                  state_q   <= S_WAKE;
               end
            end
            default: state_q <= S_HOLD;
         endcase
      end
   end

   assign flash_si    = spi_si_s & booting_q;
   assign flash_sck   = spi_sck_s;
   assign flash_cs_n  = cs_q;
   assign address     = address_q;
   assign data        = data_q;
   assign rw          = rw_q;
   assign busen       = busen_q;
   assign cpu_reset_n = cpu_q;
   assign booting     = booting_q;
   assign error       = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: a behavioural SPI flash serves random images, expected
// RAM writes and flash transactions are queued per run and checked by independent monitors.
module tb_boot_loader;

   localparam int          FAB     = 2;
   localparam logic [23:0] FBASE   = 24'h00E000;
   localparam logic [18:0] RBASE   = 19'h7FFF8;
   localparam int          LEN     = 16;
   localparam int          SDIV    = 3;
   localparam int          STARTUP = 64;
   localparam int          WAKE    = 100;
   localparam int          CMDB    = 8 + 8 * FAB;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flash_so = 1'b0;
   logic        flash_si, flash_sck, flash_cs_n, rw, busen, cpu_reset_n, booting, error;
   logic [18:0] address;
   logic [7:0]  data;

   always #5 clock = ~clock;

   boot_loader #(
      .FLASH_ADDR_BYTES(FAB), .FLASH_BASE(FBASE), .RAM_ADDR_BITS(19), .RAM_BASE(RBASE),
      .LENGTH(LEN), .SCK_DIV(SDIV), .STARTUP_CYCLES(STARTUP), .WAKE_CYCLES(WAKE),
      .CHECKSUM_EN(1'b1), .POWER_DOWN_EN(1'b1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .flash_so(flash_so), .flash_si(flash_si),
      .flash_sck(flash_sck), .flash_cs_n(flash_cs_n), .address(address), .data(data), .rw(rw),
      .busen(busen), .cpu_reset_n(cpu_reset_n), .booting(booting), .error(error)
   );

   typedef struct { logic [18:0] addr; logic [7:0] data; } wr_t;
   typedef struct { int nbits; logic [23:0] head; } txn_t;

   int          checks = 0;
   int          failures = 0;
   int          wr_seen = 0;
   wr_t         exp_wr[$];
   txn_t        exp_tx[$];
   wr_t         mon_w;
   txn_t        mon_t;
   logic [7:0]  fmem [0:LEN];
   bit          exp_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // mode 0: image 0x00..0x0F with good check byte; 1: same image, check byte 0x87;
   // 2: random image, good; 3: random image, random outcome.
   task automatic plan_run(input int mode);
      int sum;
      int fix;
      bit good;
      sum = 0;
      for (int i = 0; i < LEN; i++) begin
         fmem[i] = (mode < 2) ? 8'(i) : 8'($urandom);
         sum += int'(fmem[i]);
      end
      fix = (256 - (sum % 256)) % 256;
      if (mode == 0 || mode == 2) good = 1'b1;
      else if (mode == 1) good = 1'b0;
      else good = 1'($urandom_range(0, 1));
      if (mode == 1) fmem[LEN] = 8'h87;
      else if (good) fmem[LEN] = 8'(fix);
      else fmem[LEN] = 8'((fix + 1 + int'($urandom_range(0, 254))) % 256);
      exp_pass = good;
      for (int i = 0; i < LEN; i++)
         exp_wr.push_back('{addr: 19'((32'(RBASE) + 32'(i)) & 32'h7FFFF), data: fmem[i]});
      exp_tx.push_back('{nbits: 8, head: 24'h0000AB});
      exp_tx.push_back('{nbits: CMDB + 8 * (LEN + 1), head: {8'h03, FBASE[15:0]}});
      if (good) exp_tx.push_back('{nbits: 8, head: 24'h0000B9});
   endtask

   // Behavioural SPI flash: collects command bits, then streams bytes after a READ.
   int          fbits = 0;
   logic [23:0] fhead = 24'd0;
   always @(negedge flash_cs_n) begin
      fbits = 0;
      fhead = 24'd0;
   end
   always @(posedge flash_sck) begin
      if (flash_cs_n === 1'b0) begin
         if (fbits < 24) fhead = {fhead[22:0], flash_si};
         fbits++;
      end
   end
   always @(negedge flash_sck) begin
      int idx, b;
      if (flash_cs_n === 1'b0 && fbits >= CMDB && fhead[23:16] == 8'h03) begin
         idx = (fbits - CMDB) / 8;
         b   = 7 - ((fbits - CMDB) % 8);
         if (idx <= LEN) flash_so = fmem[idx][b];
         else flash_so = 1'b1;
      end
   end

   // Transaction monitor: each CS-high edge closes one flash transaction.
   always @(posedge flash_cs_n) begin
      if (reset !== 1'b1) begin
         chk("txn_expected", 32'(exp_tx.size() != 0), 32'd1);
         if (exp_tx.size() != 0) begin
            mon_t = exp_tx.pop_front();
            chk("txn_bits", 32'(fbits), 32'(mon_t.nbits));
            chk("txn_head", {8'd0, fhead}, {8'd0, mon_t.head});
         end
      end
   end

   // Write monitor: every rw=0 cycle must match the next expected RAM write.
   always @(negedge clock) begin
      if (reset !== 1'b1 && rw === 1'b0) begin
         wr_seen++;
         chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
         if (exp_wr.size() != 0) begin
            mon_w = exp_wr.pop_front();
            chk("write_addr", 32'(address), 32'(mon_w.addr));
            chk("write_data", 32'(data), 32'(mon_w.data));
         end
      end
   end

   // SCK phase monitor: each high phase lasts SCK_DIV cycles, each low phase at least that.
   int hi_cnt = 0;
   int lo_cnt = 0;
   always @(negedge clock) begin
      if (reset === 1'b1 || flash_cs_n !== 1'b0) begin
         hi_cnt = 0;
         lo_cnt = 0;
      end else if (flash_sck === 1'b1) begin
         if (lo_cnt != 0) chk("sck_low_min", 32'(lo_cnt >= SDIV), 32'd1);
         lo_cnt = 0;
         hi_cnt++;
      end else begin
         if (hi_cnt != 0) chk("sck_high", 32'(hi_cnt), 32'(SDIV));
         hi_cnt = 0;
         lo_cnt++;
      end
   end

   task automatic pulse_start();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (booting !== 1'b0 && n < 20000) begin
         @(negedge clock);
         n++;
      end
      chk("boot_finishes", 32'(booting), 32'd0);
   endtask

   task automatic check_end();
      chk("end_busen", 32'(busen), 32'(exp_pass));
      chk("end_cpu_reset_n", 32'(cpu_reset_n), 32'(exp_pass));
      chk("end_error", 32'(error), 32'(!exp_pass));
      chk("end_cs_n", 32'(flash_cs_n), 32'd1);
      repeat (20) @(negedge clock);
      chk("idle_si", 32'(flash_si), 32'd0);
      chk("idle_rw", 32'(rw), 32'd1);
      if (exp_pass) begin
         chk("done_address", 32'(address), 32'd0);
         chk("done_data", 32'(data), 32'd0);
      end
      chk("writes_left", 32'(exp_wr.size()), 32'd0);
      chk("txns_left", 32'(exp_tx.size()), 32'd0);
   endtask

   initial begin
      int base;
      int n;
      repeat (2) @(negedge clock);
      chk("rst_si", 32'(flash_si), 32'd0);
      chk("rst_sck", 32'(flash_sck), 32'd0);
      chk("rst_cs_n", 32'(flash_cs_n), 32'd1);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_rw", 32'(rw), 32'd1);
      chk("rst_busen", 32'(busen), 32'd0);
      chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
      chk("rst_booting", 32'(booting), 32'd1);
      chk("rst_error", 32'(error), 32'd0);

      // Run 1: known image, good checksum, from power-on.
      plan_run(0);
      reset = 1'b0;
      wait_done();
      check_end();

      // Run 2: bad check byte ends in the failure state.
      plan_run(1);
      pulse_start();
      wait_done();
      check_end();

      // Run 3: start clears the error; a start during loading is ignored.
      plan_run(2);
      pulse_start();
      chk("restart_error", 32'(error), 32'd0);
      chk("restart_booting", 32'(booting), 32'd1);
      chk("restart_busen", 32'(busen), 32'd0);
      base = wr_seen;
      n = 0;
      while (wr_seen < base + 2 && n < 20000) begin
         @(negedge clock);
         n++;
      end
      chk("reach_write2", 32'(wr_seen - base), 32'd2);
      pulse_start();
      wait_done();
      check_end();

      // Run 4: asynchronous reset during the 5th byte, then a full restart from hold.
      plan_run(2);
      pulse_start();
      base = wr_seen;
      n = 0;
      while (wr_seen < base + 4 && n < 20000) begin
         @(negedge clock);
         n++;
      end
      repeat (6) @(negedge clock);
      chk("mid_byte_cs_low", 32'(flash_cs_n), 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("arst_cs_n", 32'(flash_cs_n), 32'd1);
      chk("arst_rw", 32'(rw), 32'd1);
      chk("arst_booting", 32'(booting), 32'd1);
      chk("arst_busen", 32'(busen), 32'd0);
      exp_wr.delete();
      exp_tx.delete();
      repeat (2) @(negedge clock);
      plan_run(3);
      reset = 1'b0;
      n = 0;
      while (flash_cs_n === 1'b1 && n < 1000) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("hold_min", 32'(n >= STARTUP), 32'd1);
      chk("hold_max", 32'(n <= STARTUP + 2), 32'd1);
      wait_done();
      check_end();

      // Runs 5-7: random images with random outcomes.
      for (int r = 0; r < 3; r++) begin
         plan_run(3);
         pulse_start();
         wait_done();
         check_end();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
